// File: rtl/sc_pkg.sv
// sc_pkg: shared slow-control bus constants, error bit positions and responder FSM states.
package sc_pkg;
  localparam int SC_ERR_PORT    = 0;
  localparam int SC_ERR_ADDR    = 1;
  localparam int SC_ERR_SUBADDR = 2;
  localparam logic [15:0] FLASH_SC_PORT = 16'h2777;
  localparam logic [31:0] FLASH_IP_ADDR = 32'h00FFC000;
  typedef enum logic [1:0] {SC_IDLE, SC_WAIT, SC_ACK, SC_RELEASE} sc_state_e;
endpackage

// File: rtl/cfg_word_bank.sv
// cfg_word_bank: NWORDS x 16-bit register file with one read port, one sync write port
// and async reset to the configured IP words; words 0/1 exposed directly.
module cfg_word_bank #(
  parameter int          NWORDS  = 16,
  parameter int          AW      = 4,
  parameter logic [15:0] INIT_W0 = 16'h8479,
  parameter logic [15:0] INIT_W1 = 16'h0aa0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata,
  output logic [15:0]   word0,
  output logic [15:0]   word1
);
  logic [15:0] mem_q [NWORDS];
  logic [15:0] mem_d [NWORDS];
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[idx] = wdata;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NWORDS; i++) mem_q[i] <= (i == 0) ? INIT_W0 : (i == 1) ? INIT_W1 : 16'h0;
    end else begin
      mem_q <= mem_d;
    end
  end
  assign rdata = mem_q[idx];
  assign word0 = mem_q[0];
  assign word1 = mem_q[1];
endmodule

// File: rtl/flash_cfg_sc_responder.sv
// flash_cfg_sc_responder: SC-bus slave serving the flash configuration sector with
// flash-like read/write latency from a small register bank.
module flash_cfg_sc_responder
  import sc_pkg::*;
#(
  parameter logic [15:0] SC_PORT   = FLASH_SC_PORT,
  parameter logic [31:0] BASE_ADDR = FLASH_IP_ADDR,
  parameter int          NWORDS    = 16,
  parameter logic [31:0] SUBADDR   = 32'h000000FF,
  parameter int          RD_LAT    = 4,
  parameter int          WR_LAT    = 8,
  parameter logic [15:0] INIT_W0   = 16'h8479,
  parameter logic [15:0] INIT_W1   = 16'h0aa0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sc_port,
  input  logic [31:0] sc_addr,
  input  logic [31:0] sc_subaddr,
  input  logic [31:0] sc_data,
  input  logic        sc_op,
  input  logic        sc_frame,
  input  logic        sc_wr,
  output logic        sc_ack,
  output logic [31:0] sc_rply_data,
  output logic [31:0] sc_rply_error,
  output logic [31:0] cfg_ip
);
  localparam int          AW       = $clog2(NWORDS);
  localparam logic [7:0]  RD_L     = 8'(RD_LAT);
  localparam logic [7:0]  WR_L     = 8'(WR_LAT);
  localparam logic [32:0] ADDR_TOP = {1'b0, BASE_ADDR} + 33'(NWORDS - 1);
  localparam logic [AW-1:0] BASE_IDX = BASE_ADDR[AW-1:0];
  sc_state_e       state_q, state_d;
  logic [7:0]      cnt_q, cnt_d, lat_in;
  logic            wr_q, wr_d, op_wr, req, commit;
  logic [AW-1:0]   idx_q, idx_d, idx_in, op_idx;
  logic [15:0]     data_q, data_d, op_data, rdata, word0, word1;
  logic [31:0]     rply_data_q, rply_data_d, rply_err_q, rply_err_d;
  logic [2:0]      err;
  logic            unused_hi;
  assign unused_hi = ^sc_data[31:16];
  always_comb begin
    err = '0;
    err[SC_ERR_PORT] = sc_port != SC_PORT;
    err[SC_ERR_ADDR] = sc_addr < BASE_ADDR || {1'b0, sc_addr} > ADDR_TOP;
    err[SC_ERR_SUBADDR] = sc_subaddr != SUBADDR;
    idx_in = sc_addr[AW-1:0] - BASE_IDX;
    lat_in = sc_wr ? WR_L : RD_L;
    req = state_q == SC_IDLE && sc_frame && sc_op;
    // zero latency commits on the request edge itself, so the op comes straight from the bus
    op_wr = state_q == SC_IDLE ? sc_wr : wr_q;
    op_idx = state_q == SC_IDLE ? idx_in : idx_q;
    op_data = state_q == SC_IDLE ? sc_data[15:0] : data_q;
    commit = state_q == SC_IDLE ? (req && err == 3'b0 && lat_in == 8'd0)
                                : (state_q == SC_WAIT && sc_frame && cnt_q == 8'd1);
    state_d = state_q;
    cnt_d = cnt_q;
    wr_d = wr_q;
    idx_d = idx_q;
    data_d = data_q;
    rply_data_d = rply_data_q;
    rply_err_d = rply_err_q;
    case (state_q)
      SC_IDLE: if (req) begin
        wr_d = sc_wr;
        idx_d = idx_in;
        data_d = sc_data[15:0];
        cnt_d = lat_in;
        state_d = (err != 3'b0 || lat_in == 8'd0) ? SC_ACK : SC_WAIT;
        if (err != 3'b0) begin
          rply_data_d = '0;
          rply_err_d = {29'h0, err};
        end
      end
      SC_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        state_d = !sc_frame ? SC_IDLE : cnt_q == 8'd1 ? SC_ACK : SC_WAIT;
      end
      SC_ACK: state_d = sc_frame ? SC_ACK : SC_RELEASE;
      default: state_d = SC_IDLE;
    endcase
    if (commit) begin
      rply_data_d = op_wr ? 32'h0 : {16'h0, rdata};
      rply_err_d = '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SC_IDLE;
      cnt_q <= '0;
      wr_q <= 1'b0;
      idx_q <= '0;
      data_q <= '0;
      rply_data_q <= '0;
      rply_err_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      idx_q <= idx_d;
      data_q <= data_d;
      rply_data_q <= rply_data_d;
      rply_err_q <= rply_err_d;
    end
  end
  cfg_word_bank #(.NWORDS(NWORDS), .AW(AW), .INIT_W0(INIT_W0), .INIT_W1(INIT_W1)) u_bank (
    .clk(clk), .reset(reset), .we(commit && op_wr), .idx(op_idx), .wdata(op_data),
    .rdata(rdata), .word0(word0), .word1(word1)
  );
  assign sc_ack = state_q == SC_ACK;
  assign sc_rply_data = rply_data_q;
  assign sc_rply_error = rply_err_q;
  assign cfg_ip = {word1, word0};
endmodule
